// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequencer for the RV32M divide path (DIV/DIVU/REM/REMU).
// Radix-2 non-restoring core, two steps per cycle, with sign fix-up and the
// RISC-V divide-by-zero / signed-overflow special cases.
// Optional macro DIV_REUSE_EN: keeps the last completed operation and returns
// the stored quotient/remainder for a repeated request (DIV+REM pair) without
// running the core again.
module div_seq_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  busy
);

    localparam int W    = DATA_WIDTH;
    localparam int ITER = W / 2;
    localparam int CW   = $clog2(ITER + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);
    localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [W:0]      a_q, a_d;          // partial remainder, W+1 bits signed
    logic [W-1:0]    q_q, q_d;          // quotient bits shifting in
    logic [W-1:0]    m_q, m_d;          // divisor magnitude
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rem_sel_q, rem_sel_d;
    logic            neg_q_q, neg_q_d;
    logic            neg_r_q, neg_r_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [W-1:0]    result_q, result_d;

`ifdef DIV_REUSE_EN
    logic [W-1:0]    rq_dvd_q, rq_dvd_d;  // operands of the op in flight
    logic [W-1:0]    rq_dvs_q, rq_dvs_d;
    logic            rq_op0_q, rq_op0_d;
    logic            rv_valid_q, rv_valid_d;  // stored entry of last completed op
    logic [W-1:0]    rv_dvd_q, rv_dvd_d;
    logic [W-1:0]    rv_dvs_q, rv_dvs_d;
    logic            rv_op0_q, rv_op0_d;
    logic [W-1:0]    rv_quo_q, rv_quo_d;
    logic [W-1:0]    rv_rem_q, rv_rem_d;
    logic            reuse_hit;
`endif

    // One non-restoring step: shift {A,Q} left, add or subtract M by the sign
    // of A, and shift in the inverted new sign as the quotient bit.
    function automatic logic [2*W:0] nr_step(input logic [W:0]   a,
                                             input logic [W-1:0] q,
                                             input logic [W-1:0] m);
        logic [W:0] a_sh;
        logic [W:0] a_n;
        a_sh = {a[W-1:0], q[W-1]};
        a_n  = a[W] ? (a_sh + {1'b0, m}) : (a_sh - {1'b0, m});
        return {a_n, q[W-2:0], ~a_n[W]};
    endfunction

    logic [2*W:0] step1, step2;
    logic         dvd_neg, dvs_neg;
    logic [W-1:0] dvd_abs, dvs_abs;
    logic         div_zero, sgn_ovf;
    logic [W-1:0] r_mag, q_fin, r_fin;

    assign step1 = nr_step(a_q, q_q, m_q);
    assign step2 = nr_step(step1[2*W:W], step1[W-1:0], m_q);

    // Magnitudes are taken only for the signed ops (op[0]=0).
    assign dvd_neg  = ~op[0] & dividend[W-1];
    assign dvs_neg  = ~op[0] & divisor[W-1];
    assign dvd_abs  = dvd_neg ? ({W{1'b0}} - dividend) : dividend;
    assign dvs_abs  = dvs_neg ? ({W{1'b0}} - divisor) : divisor;
    assign div_zero = (divisor == {W{1'b0}});
    assign sgn_ovf  = ~op[0] & (dividend == MIN_NEG) & (divisor == {W{1'b1}});

    // Remainder restore folds into a W-bit add: the true remainder is < M,
    // so the carry out of the restore is never needed.
    assign r_mag = a_q[W-1:0] + (a_q[W] ? m_q : {W{1'b0}});
    assign q_fin = neg_q_q ? ({W{1'b0}} - q_q) : q_q;
    assign r_fin = neg_r_q ? ({W{1'b0}} - r_mag) : r_mag;

`ifdef DIV_REUSE_EN
    assign reuse_hit = rv_valid_q & (rv_dvd_q == dividend) &
                       (rv_dvs_q == divisor) & (rv_op0_q == op[0]);
`endif

    // Next-state and datapath updates for the divide sequencer.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        rem_sel_d = rem_sel_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        tag_d     = tag_q;
        result_d  = result_q;
`ifdef DIV_REUSE_EN
        rq_dvd_d   = rq_dvd_q;
        rq_dvs_d   = rq_dvs_q;
        rq_op0_d   = rq_op0_q;
        rv_valid_d = rv_valid_q;
        rv_dvd_d   = rv_dvd_q;
        rv_dvs_d   = rv_dvs_q;
        rv_op0_d   = rv_op0_q;
        rv_quo_d   = rv_quo_q;
        rv_rem_d   = rv_rem_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    tag_d     = in_tag;
                    rem_sel_d = op[1];
`ifdef DIV_REUSE_EN
                    rq_dvd_d  = dividend;
                    rq_dvs_d  = divisor;
                    rq_op0_d  = op[0];
`endif
                    if (div_zero) begin
                        result_d = op[1] ? dividend : {W{1'b1}};
                        state_d  = S_DONE;
`ifdef DIV_REUSE_EN
                        rv_valid_d = 1'b1;
                        rv_dvd_d   = dividend;
                        rv_dvs_d   = divisor;
                        rv_op0_d   = op[0];
                        rv_quo_d   = {W{1'b1}};
                        rv_rem_d   = dividend;
`endif
                    end else if (sgn_ovf) begin
                        result_d = op[1] ? {W{1'b0}} : MIN_NEG;
                        state_d  = S_DONE;
`ifdef DIV_REUSE_EN
                        rv_valid_d = 1'b1;
                        rv_dvd_d   = dividend;
                        rv_dvs_d   = divisor;
                        rv_op0_d   = op[0];
                        rv_quo_d   = MIN_NEG;
                        rv_rem_d   = {W{1'b0}};
`endif
`ifdef DIV_REUSE_EN
                    end else if (reuse_hit) begin
                        result_d = op[1] ? rv_rem_q : rv_quo_q;
                        state_d  = S_DONE;
`endif
                    end else begin
                        a_d     = {(W+1){1'b0}};
                        q_d     = dvd_abs;
                        m_d     = dvs_abs;
                        cnt_d   = {CW{1'b0}};
                        neg_q_d = dvd_neg ^ dvs_neg;
                        neg_r_d = dvd_neg;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                a_d   = step2[2*W:W];
                q_d   = step2[W-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_FIX: begin
                result_d = rem_sel_q ? r_fin : q_fin;
                state_d  = S_DONE;
`ifdef DIV_REUSE_EN
                rv_valid_d = 1'b1;
                rv_dvd_d   = rq_dvd_q;
                rv_dvs_d   = rq_dvs_q;
                rv_op0_d   = rq_op0_q;
                rv_quo_d   = q_fin;
                rv_rem_d   = r_fin;
`endif
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            rem_sel_q <= 1'b0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            tag_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            rem_sel_q <= rem_sel_d;
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
            tag_q     <= tag_d;
            result_q  <= result_d;
        end
    end

`ifdef DIV_REUSE_EN
    // Reuse storage; the entry is invalid after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rq_dvd_q   <= '0;
            rq_dvs_q   <= '0;
            rq_op0_q   <= 1'b0;
            rv_valid_q <= 1'b0;
            rv_dvd_q   <= '0;
            rv_dvs_q   <= '0;
            rv_op0_q   <= 1'b0;
            rv_quo_q   <= '0;
            rv_rem_q   <= '0;
        end else begin
            rq_dvd_q   <= rq_dvd_d;
            rq_dvs_q   <= rq_dvs_d;
            rq_op0_q   <= rq_op0_d;
            rv_valid_q <= rv_valid_d;
            rv_dvd_q   <= rv_dvd_d;
            rv_dvs_q   <= rv_dvs_d;
            rv_op0_q   <= rv_op0_d;
            rv_quo_q   <= rv_quo_d;
            rv_rem_q   <= rv_rem_d;
        end
    end
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign out_tag   = tag_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl (W=32). Latency is counted in rising edges
// after the accept edge until out_valid is seen: 17 for the core path, 0 for
// the special cases and (with DIV_REUSE_EN) reuse hits.
module tb_div_seq_ctrl;

    localparam int W  = 32;
    localparam int TW = 5;
`ifdef DIV_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready, busy;
    logic [1:0]    op;
    logic [W-1:0]  dividend, divisor, result;
    logic [TW-1:0] in_tag, out_tag;

    int checks = 0;
    int errors = 0;

    div_seq_ctrl #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .dividend(dividend), .divisor(divisor), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    // kind: 0 core path, 1 special case, 2 core path that is a reuse hit
    typedef struct {
        logic [1:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [TW-1:0] tag;
        logic [W-1:0]  exp;
        int            kind;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [TW-1:0] t,
                          input logic [W-1:0] exp_r, input int exp_lat);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
        op = o; dividend = a; divisor = b; in_tag = t; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " result"}, result, exp_r);
        chk({name, " tag"}, {27'd0, out_tag}, {27'd0, t});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{2'b01, 32'd100,        32'd7,          5'd3,  32'd14,         0};
        vecs[1]  = '{2'b11, 32'd100,        32'd7,          5'd4,  32'd2,          2};
        vecs[2]  = '{2'b00, 32'hFFFFFFF9,   32'd2,          5'd5,  32'hFFFFFFFD,   0};
        vecs[3]  = '{2'b10, 32'hFFFFFFF9,   32'd2,          5'd6,  32'hFFFFFFFF,   2};
        vecs[4]  = '{2'b00, 32'd7,          32'hFFFFFFFE,   5'd7,  32'hFFFFFFFD,   0};
        vecs[5]  = '{2'b10, 32'd7,          32'hFFFFFFFE,   5'd8,  32'd1,          2};
        vecs[6]  = '{2'b00, 32'd5,          32'd0,          5'd9,  32'hFFFFFFFF,   1};
        vecs[7]  = '{2'b10, 32'd5,          32'd0,          5'd10, 32'd5,          1};
        vecs[8]  = '{2'b00, 32'h80000000,   32'hFFFFFFFF,   5'd11, 32'h80000000,   1};
        vecs[9]  = '{2'b10, 32'h80000000,   32'hFFFFFFFF,   5'd12, 32'd0,          1};
        vecs[10] = '{2'b00, 32'd1000,       32'd33,         5'd13, 32'd30,         0};
        vecs[11] = '{2'b10, 32'd1000,       32'd33,         5'd14, 32'd10,         2};
        vecs[12] = '{2'b11, 32'd1000,       32'd33,         5'd15, 32'd10,         0};
        vecs[13] = '{2'b01, 32'hFFFFFFFF,   32'd1,          5'd16, 32'hFFFFFFFF,   0};
        vecs[14] = '{2'b00, 32'h80000000,   32'd1,          5'd17, 32'h80000000,   0};
        vecs[15] = '{2'b10, 32'hFFFFFF9C,   32'hFFFFFFF9,   5'd18, 32'hFFFFFFFE,   0};
        vecs[16] = '{2'b01, 32'd5,          32'd0,          5'd19, 32'hFFFFFFFF,   1};
        vecs[17] = '{2'b11, 32'h80000000,   32'hFFFFFFFF,   5'd20, 32'h80000000,   0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = 2'b00; dividend = '0; divisor = '0; in_tag = '0;
        #2;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset tag", {27'd0, out_tag}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            int lat;
            lat = (vecs[i].kind == 1) ? 0 : ((vecs[i].kind == 2 && REUSE) ? 0 : 17);
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].tag, vecs[i].exp, lat);
        end

        // Backpressure: result held for 10 cycles with out_ready low.
        op = 2'b01; dividend = 32'd200; divisor = 32'd9; in_tag = 5'd21; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp busy in CALC", {31'd0, busy}, 32'd1);
        chk("bp in_ready in CALC", {31'd0, in_ready}, 32'd0);
        for (int k = 0; k < 40 && !out_valid; k++) begin
            @(posedge clk); #1;
        end
        chk("bp out_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b1; dividend = 32'd1; divisor = 32'd1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("bp hold valid", {31'd0, out_valid}, 32'd1);
            chk("bp hold result", result, 32'd22);
            chk("bp hold tag", {27'd0, out_tag}, 32'd21);
            chk("bp hold in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp release out_valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of a core-path op.
        op = 2'b01; dividend = 32'd50000; divisor = 32'd7; in_tag = 5'd22; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midreset in_ready", {31'd0, in_ready}, 32'd1);
        chk("midreset out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset busy", {31'd0, busy}, 32'd0);
        chk("midreset result", result, 32'd0);
        chk("midreset tag", {27'd0, out_tag}, 32'd0);
        @(negedge clk); rst = 1'b0;
        run_op("post reset divu", 2'b01, 32'd9, 32'd3, 5'd23, 32'd3, 17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
